// File: rtl/hub75_rx_decoder.sv
// hub75_rx_decoder: receive-side decoder for a HUB75 panel bus.
// Oversamples the panel bus in the clk domain, rebuilds each shifted line
// into per-column pixel records, tracks the PWM slice from row-address wrap
// and streams the records out over a valid/ready port.
//
// Optional feature macro: HUB75_RX_OE_CHECK_EN (enables the oe_err checker).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   hub_clk/lat/oe      panel shift clock, latch, output enable (active-low)
//   hub_addr            row address
//   hub_rgb1/hub_rgb2   top / bottom half R,G,B bits
//   px_valid/px_ready   record handshake
//   px_col/px_row       column index (arrival order) / row captured at latch
//   px_rgb_top/_bot     pixel bits of the top / bottom half
//   px_slice            PWM slice index of the line
//   frame_start         one-cycle pulse when the slice wraps to 0
//   col_err, overrun    sticky error flags
//   oe_err              sticky OE-while-latching/addressing flag (optional)
module hub75_rx_decoder #(
    parameter int unsigned COLS        = 64,
    parameter int unsigned COL_W       = 6,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned PWM_W       = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hub_clk,
    input  logic              hub_lat,
    input  logic              hub_oe,
    input  logic [ADDR_W-1:0] hub_addr,
    input  logic [2:0]        hub_rgb1,
    input  logic [2:0]        hub_rgb2,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [COL_W-1:0]  px_col,
    output logic [ADDR_W-1:0] px_row,
    output logic [2:0]        px_rgb_top,
    output logic [2:0]        px_rgb_bot,
    output logic [PWM_W-1:0]  px_slice,
    output logic              frame_start,
    output logic              col_err,
    output logic              overrun,
    output logic              oe_err
);

    localparam int unsigned CNT_W = COL_W + 1;
    localparam int unsigned PIX_W = 6;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Input synchronizers; data rides the same stage as the shift clock.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] lat_sync;
    logic [ADDR_W-1:0]      addr_sync [SYNC_STAGES];
    logic [PIX_W-1:0]       pix_sync  [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            lat_sync <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                addr_sync[i] <= '0;
                pix_sync[i]  <= '0;
            end
        end else begin
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], hub_clk};
            lat_sync     <= {lat_sync[SYNC_STAGES-2:0], hub_lat};
            addr_sync[0] <= hub_addr;
            pix_sync[0]  <= {hub_rgb1, hub_rgb2};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                addr_sync[i] <= addr_sync[i-1];
                pix_sync[i]  <= pix_sync[i-1];
            end
        end
    end

    logic              clk_s;
    logic              lat_s;
    logic [ADDR_W-1:0] addr_s;
    logic [PIX_W-1:0]  pix_s;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign lat_s  = lat_sync[SYNC_STAGES-1];
    assign addr_s = addr_sync[SYNC_STAGES-1];
    assign pix_s  = pix_sync[SYNC_STAGES-1];

    // Previous-value registers for edge detection.
    logic clk_prev;
    logic lat_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev <= 1'b0;
            lat_prev <= 1'b0;
        end else begin
            clk_prev <= clk_s;
            lat_prev <= lat_s;
        end
    end

    logic clk_rise;
    logic lat_rise;

    assign clk_rise = clk_s & ~clk_prev;
    assign lat_rise = lat_s & ~lat_prev;

    // Line state.
    logic [PIX_W-1:0]  shift_buf [COLS];
    logic [PIX_W-1:0]  hold_buf  [COLS];
    logic [CNT_W-1:0]  shift_cnt;
    logic              shift_ovf;
    logic [ADDR_W-1:0] prev_addr;
    logic [PWM_W-1:0]  slice_q;
    logic [0:0]        state_q;
    logic [0:0]        state_d;

    logic              do_shift;
    logic              extra_edge;
    logic [CNT_W-1:0]  cnt_eff;
    logic              line_ok;
    logic              wrap;
    logic [PWM_W-1:0]  slice_inc;
    logic [PWM_W-1:0]  slice_next;
    logic              accept;
    logic              last;
    logic              start;
    logic [COL_W-1:0]  col_nxt;

    assign do_shift   = clk_rise && (shift_cnt < CNT_W'(COLS));
    assign extra_edge = clk_rise && !do_shift;
    assign cnt_eff    = shift_cnt + CNT_W'(do_shift);
    assign line_ok    = (cnt_eff == CNT_W'(COLS)) && !shift_ovf && !extra_edge;
    assign wrap       = lat_rise && (addr_s < prev_addr);
    assign slice_inc  = slice_q + PWM_W'(1);
    assign slice_next = wrap ? slice_inc : slice_q;
    assign accept     = (state_q == ST_DRAIN) && px_ready;
    assign last       = accept && (px_col == COL_W'(COLS - 1));
    assign start      = lat_rise && (state_q == ST_IDLE);
    assign col_nxt    = px_col + COL_W'(1);

    // Line content as it stands after this cycle's shift (shift before latch);
    // columns never shifted this line read as 0.
    logic [PIX_W-1:0] line_d [COLS];

    always_comb begin
        for (int i = 0; i < int'(COLS); i++) begin
            line_d[i] = '0;
            if (do_shift && (shift_cnt == CNT_W'(i))) begin
                line_d[i] = pix_s;
            end else if (CNT_W'(i) < shift_cnt) begin
                line_d[i] = shift_buf[i];
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_DRAIN;
            ST_DRAIN: if (last)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shift buffer write; entries beyond shift_cnt are masked, so no clear needed.
    always_ff @(posedge clk) begin
        if (do_shift) begin
            shift_buf[shift_cnt[COL_W-1:0]] <= pix_s;
        end
    end

    // Line transfer into the drain buffer.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < int'(COLS); i++) begin
                hold_buf[i] <= line_d[i];
            end
        end
    end

    // Shift count, slice tracking, sticky flags and registered record outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt   <= '0;
            shift_ovf   <= 1'b0;
            prev_addr   <= '0;
            slice_q     <= '0;
            frame_start <= 1'b0;
            col_err     <= 1'b0;
            overrun     <= 1'b0;
            px_valid    <= 1'b0;
            px_col      <= '0;
            px_row      <= '0;
            px_rgb_top  <= '0;
            px_rgb_bot  <= '0;
            px_slice    <= '0;
        end else begin
            frame_start <= 1'b0;
            px_valid    <= (state_d == ST_DRAIN);

            if (do_shift) begin
                shift_cnt <= cnt_eff;
            end
            if (extra_edge) begin
                shift_ovf <= 1'b1;
            end

            if (lat_rise) begin
                if (!line_ok) begin
                    col_err <= 1'b1;
                end
                prev_addr <= addr_s;
                slice_q   <= slice_next;
                if (wrap && (slice_inc == '0)) begin
                    frame_start <= 1'b1;
                end
                shift_cnt <= '0;
                shift_ovf <= 1'b0;
                if (state_q == ST_IDLE) begin
                    px_col     <= '0;
                    px_row     <= addr_s;
                    px_slice   <= slice_next;
                    px_rgb_top <= line_d[0][5:3];
                    px_rgb_bot <= line_d[0][2:0];
                end else begin
                    overrun <= 1'b1;
                end
            end

            // Preload the next record so outputs stay registered.
            if (accept && !last) begin
                px_col     <= col_nxt;
                px_rgb_top <= hold_buf[col_nxt][5:3];
                px_rgb_bot <= hold_buf[col_nxt][2:0];
            end
        end
    end

`ifdef HUB75_RX_OE_CHECK_EN
    // Flags the display being enabled while latching or while the address moves.
    logic [SYNC_STAGES-1:0] oe_sync;
    logic                   oe_s;
    logic [ADDR_W-1:0]      addr_prev;

    assign oe_s = oe_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_sync   <= '0;
            addr_prev <= '0;
            oe_err    <= 1'b0;
        end else begin
            oe_sync   <= {oe_sync[SYNC_STAGES-2:0], hub_oe};
            addr_prev <= addr_s;
            if (!oe_s && (lat_s || (addr_s != addr_prev))) begin
                oe_err <= 1'b1;
            end
        end
    end
`else
    logic unused_oe;
    assign unused_oe = hub_oe;
    assign oe_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_rx_decoder.sv
// Scoreboard bench for hub75_rx_decoder: stimulus pushes expected records,
// a monitor pops and compares on every accepted record.
module tb_hub75_rx_decoder;

    localparam int unsigned COLS   = 64;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PWM_W  = 5;

    typedef struct packed {
        logic [COL_W-1:0]  col;
        logic [ADDR_W-1:0] row;
        logic [2:0]        top;
        logic [2:0]        bot;
        logic [PWM_W-1:0]  slice;
    } rec_t;

    logic              clk;
    logic              rst;
    logic              hub_clk;
    logic              hub_lat;
    logic              hub_oe;
    logic [ADDR_W-1:0] hub_addr;
    logic [2:0]        hub_rgb1;
    logic [2:0]        hub_rgb2;
    logic              px_valid;
    logic              px_ready;
    logic [COL_W-1:0]  px_col;
    logic [ADDR_W-1:0] px_row;
    logic [2:0]        px_rgb_top;
    logic [2:0]        px_rgb_bot;
    logic [PWM_W-1:0]  px_slice;
    logic              frame_start;
    logic              col_err;
    logic              overrun;
    logic              oe_err;

    hub75_rx_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .hub_clk    (hub_clk),
        .hub_lat    (hub_lat),
        .hub_oe     (hub_oe),
        .hub_addr   (hub_addr),
        .hub_rgb1   (hub_rgb1),
        .hub_rgb2   (hub_rgb2),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_col     (px_col),
        .px_row     (px_row),
        .px_rgb_top (px_rgb_top),
        .px_rgb_bot (px_rgb_bot),
        .px_slice   (px_slice),
        .frame_start(frame_start),
        .col_err    (col_err),
        .overrun    (overrun),
        .oe_err     (oe_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    rec_t exp_q[$];
    bit   discard  = 1'b0;
    int   rdy_mode = 0;
    int   dut_fs   = 0;

    // Reference model state.
    logic [ADDR_W-1:0] m_prev;
    logic [PWM_W-1:0]  m_slice;
    int                m_fs;
    bit                m_col_err;
    bit                m_overrun;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] gen_top(input int k, input int pat);
        logic [6:0] kk;
        kk = 7'(k);
        return (pat == 0) ? kk[2:0] : kk[5:3];
    endfunction

    function automatic logic [2:0] gen_bot(input int k, input int pat);
        logic [6:0] kk;
        kk = 7'(k);
        return (pat == 0) ? ~kk[2:0] : (kk[2:0] ^ 3'b101);
    endfunction

    // Consumer ready pattern.
    initial begin
        int c;
        c = 0;
        px_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       px_ready = 1'b1;
                1:       px_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: px_ready = 1'b0;
            endcase
            c++;
        end
    end

    // Monitor: compares accepted records and the head column while stalled.
    initial begin
        rec_t e;
        rec_t a;
        forever begin
            @(negedge clk);
            if (!rst && frame_start) dut_fs++;
            if (!rst && !discard && px_valid) begin
                a = '{col: px_col, row: px_row, top: px_rgb_top, bot: px_rgb_bot, slice: px_slice};
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", 32'(a), 32'hFFFF_FFFF);
                end else if (px_ready) begin
                    e = exp_q.pop_front();
                    chk("record", 32'(a), 32'(e));
                end else begin
                    chk("stall_col", 32'(px_col), 32'(exp_q[0].col));
                end
            end
        end
    end

    task automatic hub_shift(input logic [2:0] r1, input logic [2:0] r2);
        @(posedge clk);
        #1;
        hub_rgb1 = r1;
        hub_rgb2 = r2;
        hub_clk  = 1'b0;
        repeat (2) @(posedge clk);
        #1 hub_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 hub_clk = 1'b0;
    endtask

    task automatic hub_latch(input logic [ADDR_W-1:0] addr, input bit chk_lat);
        @(posedge clk);
        #1 hub_addr = addr;
        repeat (2) @(posedge clk);
        #1 hub_lat = 1'b1;
        if (chk_lat) begin
            repeat (3) @(negedge clk);
            chk("valid_before_latency", 32'(px_valid), 32'd0);
            @(negedge clk);
            chk("valid_first", 32'(px_valid), 32'd1);
            @(posedge clk);
        end else begin
            repeat (2) @(posedge clk);
        end
        #1 hub_lat = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic model_latch(input logic [ADDR_W-1:0] addr);
        if (addr < m_prev) begin
            m_slice = m_slice + PWM_W'(1);
            if (m_slice == '0) m_fs++;
        end
        m_prev = addr;
    endtask

    task automatic send_line(input int ncols, input logic [ADDR_W-1:0] addr, input int pat,
                             input bit acc, input bit chk_lat);
        rec_t r;
        for (int k = 0; k < ncols; k++) hub_shift(gen_top(k, pat), gen_bot(k, pat));
        model_latch(addr);
        if (ncols != int'(COLS)) m_col_err = 1'b1;
        if (!acc) m_overrun = 1'b1;
        if (acc) begin
            for (int k = 0; k < int'(COLS); k++) begin
                r.col   = COL_W'(k);
                r.row   = addr;
                r.top   = (k < ncols) ? gen_top(k, pat) : 3'd0;
                r.bot   = (k < ncols) ? gen_bot(k, pat) : 3'd0;
                r.slice = m_slice;
                exp_q.push_back(r);
            end
        end
        hub_latch(addr, chk_lat);
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!px_valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic check_flags(input string nm);
        chk({nm, "_col_err"}, 32'(col_err), 32'(m_col_err));
        chk({nm, "_overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    task automatic model_reset();
        m_prev    = '0;
        m_slice   = '0;
        m_col_err = 1'b0;
        m_overrun = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst      = 1'b1;
        hub_clk  = 1'b0;
        hub_lat  = 1'b0;
        hub_oe   = 1'b1;
        hub_addr = '0;
        hub_rgb1 = '0;
        hub_rgb2 = '0;
        model_reset();
        m_fs = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_col", 32'(px_col), 32'd0);
        chk("rst_slice", 32'(px_slice), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_col_err", 32'(col_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_oe_err", 32'(oe_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic line, with latency check.
        rdy_mode = 0;
        send_line(64, 5'd5, 0, 1'b1, 1'b1);
        wait_idle("basic_idle");
        check_flags("basic");

        // Backpressure.
        rdy_mode = 1;
        send_line(64, 5'd7, 1, 1'b1, 1'b0);
        wait_idle("bp_idle");
        rdy_mode = 0;

        // Address wrap advances the slice.
        send_line(64, 5'd3, 0, 1'b1, 1'b0);
        wait_idle("wrap_idle");

        // Short line.
        send_line(63, 5'd4, 1, 1'b1, 1'b0);
        wait_idle("short_idle");
        check_flags("short");

        // Overrun: A held by backpressure, B dropped but its wrap counts.
        rdy_mode = 2;
        send_line(64, 5'd9, 0, 1'b1, 1'b0);
        send_line(64, 5'd2, 1, 1'b0, 1'b0);
        check_flags("overrun");
        rdy_mode = 0;
        wait_idle("overrun_idle");
        send_line(64, 5'd6, 0, 1'b1, 1'b0);
        wait_idle("post_overrun_idle");

        // Slice/frame sweep with record checking suspended.
        discard = 1'b1;
        for (int s = 0; s < 32; s++) begin
            for (int a = 0; a < 32; a++) begin
                model_latch(ADDR_W'(a));
                hub_latch(ADDR_W'(a), 1'b0);
            end
        end
        model_latch('0);
        hub_latch('0, 1'b0);
        m_col_err = 1'b1;
        wait_idle("sweep_idle");
        discard = 1'b0;
        chk("frame_start_count", 32'(dut_fs), 32'(m_fs));
        check_flags("sweep");
        send_line(64, 5'd1, 1, 1'b1, 1'b0);
        wait_idle("post_sweep_idle");

        // Reset in the middle of a drain.
        send_line(64, 5'd10, 0, 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (px_valid && px_col == COL_W'(20)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_col20", 32'(hit), 32'd1);
        discard = 1'b1;
        rst     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(px_valid), 32'd0);
        chk("midrst_col_err", 32'(col_err), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_oe_err", 32'(oe_err), 32'd0);
        chk("midrst_slice", 32'(px_slice), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        discard = 1'b0;
        repeat (10) @(negedge clk);
        chk("postrst_valid", 32'(px_valid), 32'd0);
        send_line(64, 5'd2, 1, 1'b1, 1'b0);
        wait_idle("postrst_idle");
        check_flags("postrst");

        // OE check: latch while the display is enabled.
        discard = 1'b1;
        chk("oe_err_clean", 32'(oe_err), 32'd0);
        @(posedge clk);
        #1;
        hub_oe  = 1'b0;
        hub_lat = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        hub_lat = 1'b0;
        hub_oe  = 1'b1;
        repeat (4) @(negedge clk);
`ifdef HUB75_RX_OE_CHECK_EN
        chk("oe_err_latch", 32'(oe_err), 32'd1);
`else
        chk("oe_err_latch", 32'(oe_err), 32'd0);
`endif
        wait_idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hub75_rx_decoder.md
Name: hub75_rx_decoder

Overview:
- Receive-side counterpart of the panel scan/shift driver. Oversamples the HUB75 output bus (panel clock, latch, OE, row address, two RGB lanes) in the system clock domain.
- Rebuilds each shifted line into per-column pixel records and tracks the PWM slice from row-address wrap.
- Streams the records out over a valid/ready port.
- Used for loopback checking of the panel driver and as a panel emulator front-end.

Parameters:
- COLS, 64, columns shifted per line; range 2..256.
- COL_W, 6, column index width; must satisfy 2^COL_W >= COLS.
- ADDR_W, 5, row address width.
- PWM_W, 5, PWM slice counter width.
- SYNC_STAGES, 2, synchronizer depth on all hub_* inputs; minimum 2.

Ports:
- clk  in  1  system clock; at least 4x the hub_clk frequency.
- rst  in  1  synchronous, active-high reset.
- hub_clk  in  1  panel shift clock; data is sampled on its rising edge.
- hub_lat  in  1  latch; its rising edge ends the line.
- hub_oe  in  1  output enable, active-low.
- hub_addr  in  ADDR_W  row address.
- hub_rgb1  in  3  top-half R,G,B bits.
- hub_rgb2  in  3  bottom-half R,G,B bits.
- px_valid  out  1  pixel record valid.
- px_ready  in  1  consumer ready.
- px_col  out  COL_W  column index, in arrival order, 0 = first shifted.
- px_row  out  ADDR_W  row address captured at latch; top row = {0,px_row}, bottom row = {1,px_row}.
- px_rgb_top  out  3  top pixel bits.
- px_rgb_bot  out  3  bottom pixel bits.
- px_slice  out  PWM_W  PWM slice index of this line.
- frame_start  out  1  one-cycle pulse when the slice wraps to 0.
- col_err  out  1  sticky: a latch arrived with shift count != COLS.
- overrun  out  1  sticky: a line was dropped because the previous line was still draining.
- oe_err  out  1  sticky; present only with the optional feature, otherwise tied 0.

Behaviour:
- **Synchronization.** All hub_* inputs pass through SYNC_STAGES flops. Edges are detected on the synced copies using a previous-value register. Data is taken from the same synced stage as the clock, so it stays aligned.
- **Shift capture.**
  - On a synced hub_clk rising edge with shift_cnt < COLS: write {rgb1,rgb2} into shift_buf[shift_cnt], then increment shift_cnt.
  - With shift_cnt == COLS, further edges are ignored; shift_cnt saturates and col_err is flagged at the latch.
- **Latch handling** (synced hub_lat rising edge):
  - Set col_err if shift_cnt != COLS.
  - Capture hub_addr into line_addr.
  - Slice update: if addr < prev_addr, increment slice (mod 2^PWM_W). If the new slice is 0, pulse frame_start the same cycle the slice register updates. Then prev_addr <= addr.
  - Transfer: if the drain FSM is IDLE, copy shift_buf to hold_buf and enter DRAIN. Otherwise drop the line and set overrun. The slice still updates in either case.
  - Reset shift_cnt to 0.
- **Simultaneous edges.** A hub_clk edge and a hub_lat edge in the same cycle: the shift is applied first, and the latched line includes that bit.
- **Drain FSM (IDLE, DRAIN).**
  - In DRAIN, px_valid = 1. px_col = rd_idx, and px_row, px_slice and rgb come from hold_buf[rd_idx] and the line registers.
  - On px_valid & px_ready, rd_idx increments. After rd_idx == COLS-1 is accepted, the FSM returns to IDLE and deasserts px_valid the next cycle.
  - First px_valid is asserted 1 cycle after the cycle in which the latch edge is detected.
  - Outputs stay stable while px_valid & !px_ready.
  - One record per cycle when px_ready is held high, so a line drains in COLS cycles.
- **Reset values.** px_valid, frame_start, col_err, overrun, oe_err, px_col, px_row, px_rgb_*, px_slice = 0. shift_cnt = 0, prev_addr = 0, slice = 0, FSM = IDLE. Synchronizers reset to 0.
- **Reset mid-drain.** The drain is aborted with no further records; all state returns to the reset values.
- **Sticky flags** clear only on rst.

Optional Feature:
- Macro: HUB75_RX_OE_CHECK_EN.
- **Defined:** oe_err sets on any cycle where synced hub_lat = 1 and synced hub_oe = 0 (display enabled while latching), or on a hub_addr change while synced hub_oe = 0.
- **Undefined:** oe_err is constant 0, and the checker logic and hub_oe synchronizer are removed.

Test Plan:
- **Basic line.** Shift 64 columns where column k has rgb1 = k[2:0] and rgb2 = ~k[2:0], then latch with addr = 5 and px_ready = 1.
  - Expect 64 consecutive records, px_col 0..63 with matching rgb and px_row = 5.
  - Expect px_slice = 0, col_err = 0, and px_valid first high 1 cycle after latch edge detection.
- **Backpressure.** Same line with px_ready toggled 1,0,0,1 repeating.
  - Expect every col delivered exactly once, in order, and outputs stable while stalled.
- **Slice/frame.** Latch addr 0..31 in order across 32 slices, then addr 0.
  - Expect px_slice to increment at each 31->0 wrap.
  - Expect frame_start to pulse exactly once, when the slice goes 31->0 (after the 32nd wrap).
- **Short line.** Send 63 shift edges then latch.
  - Expect col_err = 1 sticky and the line still drained with col 63 data = 0.
- **Overrun.** With px_ready = 0, deliver line A, then shift and latch line B.
  - Expect overrun = 1 and only line A records emitted once px_ready = 1.
  - Expect the slice to have advanced if B's addr wrapped.
- **Reset and OE check.**
  - Assert rst mid-drain at col 20: px_valid = 0 next cycle and all flags 0.
  - With HUB75_RX_OE_CHECK_EN defined, drive hub_lat = 1 while hub_oe = 0: oe_err = 1.
